md_unit_iter: RTL

//  Parametrised multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS core.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_div_core.sv | 34 +++
 rtl/md_unit_iter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared types for the multiply/divide unit: opcodes, FSM states and issue decoding.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

  // True for the ops that occupy the unit for more than one cycle.
  function automatic logic is_md_start(input md_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational restoring-divide slice: resolves STEP quotient bits per call, MSB first.
module md_div_core #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] dvd_out,
  output logic [STEP-1:0]  q_bits
);

  logic [WIDTH-1:0] rem_s [STEP+1];
  logic [WIDTH-1:0] dvd_s [STEP+1];

  assign rem_s[0] = rem_in;
  assign dvd_s[0] = dvd_in;

  for (genvar gi = 0; gi < STEP; gi++) begin : g_step
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    // rem < divisor always holds, so trial < 2*divisor and diff[WIDTH] is a clean borrow flag.
    assign trial = {rem_s[gi], dvd_s[gi][WIDTH-1]};
    assign diff  = trial - {1'b0, divisor};
    assign q_bits[STEP-1-gi] = ~diff[WIDTH];
    assign rem_s[gi+1] = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_s[gi+1] = {dvd_s[gi][WIDTH-2:0], 1'b0};
  end

  assign rem_out = rem_s[STEP];
  assign dvd_out = dvd_s[STEP];

endmodule

// File: rtl/md_unit_iter.sv
// Multi-cycle MULT/DIV unit with HI/LO for the EX stage; the dividend register doubles as the quotient.
module md_unit_iter
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_LAT  = 5,
  parameter int DIV_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DIV_CYC = WIDTH / DIV_STEP;
  localparam int CNT_MAX = (MUL_LAT > DIV_CYC) ? MUL_LAT : DIV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   hi_reg, hi_next, lo_reg, lo_next;
  logic               done_reg, done_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic [WIDTH-1:0]   rem_reg, rem_next, dvd_reg, dvd_next, dsr_reg, dsr_next;
  logic               neg_q_reg, neg_q_next, neg_r_reg, neg_r_next, dz_reg, dz_next;

  md_op_e             op_e;
  logic               is_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   rem_step, dvd_step;
  logic [DIV_STEP-1:0] q_step;

  assign op_e      = md_op_e'(op);
  assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign ext_a     = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign ext_b     = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod      = ext_a * ext_b;
  // Negating MIN yields MIN again, which is exactly its unsigned magnitude.
  assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

  md_div_core #(.WIDTH(WIDTH), .STEP(DIV_STEP)) u_div_core (
    .rem_in  (rem_reg),
    .dvd_in  (dvd_reg),
    .divisor (dsr_reg),
    .rem_out (rem_step),
    .dvd_out (dvd_step),
    .q_bits  (q_step)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;
    prod_next  = prod_reg;
    rem_next   = rem_reg;
    dvd_next   = dvd_reg;
    dsr_next   = dsr_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    dz_next    = dz_reg;
    case (state_reg)
      IDLE: begin
        if (start && !cancel) begin
          if (op_e == OP_MTHI) hi_next = a;
          if (op_e == OP_MTLO) lo_next = a;
          if (is_md_start(op_e)) begin
            if (op_e == OP_MULT || op_e == OP_MULTU) begin
              prod_next  = prod;
              cnt_next   = CNT_W'(MUL_LAT - 1);
              state_next = MUL;
            end else begin
              rem_next   = '0;
              dvd_next   = a_mag;
              dsr_next   = b_mag;
              neg_q_next = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r_next = is_signed && a[WIDTH-1];
              dz_next    = (b == '0);
              cnt_next   = CNT_W'(DIV_CYC - 1);
              state_next = DIV;
            end
          end
        end
      end
      MUL: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          {hi_next, lo_next} = prod_reg;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DIV: begin
        if (cancel) begin
          state_next = IDLE;
        end else begin
          rem_next = rem_step;
          dvd_next = dvd_step | WIDTH'(q_step);
          if (cnt_reg == '0) state_next = FIX;
          else               cnt_next   = cnt_reg - 1'b1;
        end
      end
      FIX: begin
        if (cancel) begin
          state_next = IDLE;
        end else begin
          // Divide by zero still reports completion but leaves HI/LO untouched.
          if (!dz_reg) begin
            hi_next = neg_r_reg ? -rem_reg : rem_reg;
            lo_next = neg_q_reg ? -dvd_reg : dvd_reg;
          end
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
      prod_reg  <= '0;
      rem_reg   <= '0;
      dvd_reg   <= '0;
      dsr_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
      prod_reg  <= prod_next;
      rem_reg   <= rem_next;
      dvd_reg   <= dvd_next;
      dsr_reg   <= dsr_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      dz_reg    <= dz_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
